// File: rtl/smc_access_seq.sv
// Static memory controller access sequencer: splits one AHB access into SETUP/STROBE/HOLD beats to the external bus.
// Latency 3+ws cycles per beat after a one-entry pending slot; new_access outside IDLE/final HOLD/TURN is dropped.
module smc_access_seq #(
  parameter int WS_W = 4
) (
  input  logic            hclk,
  input  logic            sys_reset,
  input  logic            new_access,
  input  logic [31:0]     addr,
  input  logic [1:0]      xfer_size,
  input  logic            n_read,
  input  logic [31:0]     write_data,
  input  logic [1:0]      cfg_mem_width,
  input  logic [WS_W-1:0] cfg_ws_rd,
  input  logic [WS_W-1:0] cfg_ws_wr,
  input  logic [1:0]      cfg_turn,
  input  logic [31:0]     ext_data_in,
  output logic [31:0]     ext_addr,
  output logic            ext_n_cs,
  output logic            ext_n_oe,
  output logic            ext_n_we,
  output logic [3:0]      ext_n_be,
  output logic [31:0]     ext_data_out,
  output logic            ext_data_oe,
  output logic [31:0]     read_data,
  output logic            smc_done,
  output logic            mac_done,
  output logic            smc_idle
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_TURN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_start;

  logic            r_pend_vld;
  logic [31:0]     r_pend_addr;
  logic [1:0]      r_pend_size;
  logic            r_pend_nrd;

  logic [31:0]     r_addr;
  logic [1:0]      r_size;
  logic            r_nrd;
  logic [1:0]      r_mw;
  logic [WS_W-1:0] r_ws;
  logic [1:0]      r_turn;
  logic [1:0]      r_beat;
  logic [1:0]      r_last;
  logic [WS_W-1:0] r_cnt;
  logic [1:0]      r_tcnt;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;

  logic            w_final;
  logic            w_accept;
  logic            w_pend_any;
  logic [31:0]     w_src_addr;
  logic [1:0]      w_src_sz;
  logic            w_src_nrd;
  logic [1:0]      w_src_mw;
  logic [1:0]      w_src_last;
  logic [31:0]     w_baddr;
  logic            w_active;
  logic [31:0]     w_wsrc;
  logic [31:0]     w_wlane;
  logic [3:0]      w_be;

  assign w_final    = (r_beat == r_last);
  assign w_accept   = new_access && !r_pend_vld &&
                      ((r_state == S_IDLE) || (r_state == S_TURN) || ((r_state == S_HOLD) && w_final));
  assign w_pend_any = r_pend_vld || w_accept;

  // An access starting straight out of HOLD/TURN may come from the bus this cycle rather than the slot.
  assign w_src_addr = r_pend_vld ? r_pend_addr : addr;
  assign w_src_nrd  = r_pend_vld ? r_pend_nrd  : n_read;

  always_comb begin
    w_src_sz = r_pend_vld ? r_pend_size : xfer_size;
    if (w_src_sz == 2'd3) w_src_sz = 2'd2;
    case (cfg_mem_width)
      2'd0:    w_src_mw = 2'd0;
      2'd1:    w_src_mw = 2'd1;
      default: w_src_mw = 2'd2;
    endcase
    w_src_last = 2'd0;
    if (w_src_sz > w_src_mw) begin
      case (w_src_sz - w_src_mw)
        2'd1:    w_src_last = 2'd1;
        2'd2:    w_src_last = 2'd3;
        default: w_src_last = 2'd0;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend_vld) begin
          w_state_nxt = S_SETUP;
          w_start     = 1'b1;
        end
      end
      S_SETUP:  w_state_nxt = S_STROBE;
      S_STROBE: if (r_cnt == '0) w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (!w_final) begin
          w_state_nxt = S_SETUP;
        end else if (r_turn != 2'd0) begin
          w_state_nxt = S_TURN;
        end else if (w_pend_any) begin
          w_state_nxt = S_SETUP;
          w_start     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_TURN: begin
        if (r_tcnt == 2'd0) begin
          if (w_pend_any) begin
            w_state_nxt = S_SETUP;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_baddr  = r_addr + ({30'd0, r_beat} << r_mw);
  assign w_active = (r_state == S_SETUP) || (r_state == S_STROBE) || (r_state == S_HOLD);
  assign w_wsrc   = ((r_state == S_SETUP) && (r_beat == 2'd0)) ? write_data : r_wdata;

  always_comb begin
    case (r_mw)
      2'd0:    w_wlane = {24'd0, w_wsrc[{w_baddr[1:0], 3'b000} +: 8]};
      2'd1:    w_wlane = {16'd0, w_wsrc[{w_baddr[1], 4'b0000} +: 16]};
      default: w_wlane = w_wsrc;
    endcase
  end

  always_comb begin
    w_be = 4'hF;
    if (w_active) begin
      case (r_mw)
        2'd0: w_be = 4'b1110;
        2'd1: begin
          if (r_size == 2'd0) w_be = {2'b11, ~(2'b01 << w_baddr[0])};
          else                w_be = 4'b1100;
        end
        default: begin
          case (r_size)
            2'd0:    w_be = ~(4'b0001 << w_baddr[1:0]);
            2'd1:    w_be = ~(4'b0011 << {w_baddr[1], 1'b0});
            default: w_be = 4'b0000;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (sys_reset) begin
      r_state     <= S_IDLE;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_pend_size <= '0;
      r_pend_nrd  <= 1'b0;
      r_addr      <= '0;
      r_size      <= '0;
      r_nrd       <= 1'b0;
      r_mw        <= '0;
      r_ws        <= '0;
      r_turn      <= '0;
      r_beat      <= '0;
      r_last      <= '0;
      r_cnt       <= '0;
      r_tcnt      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_start) begin
        r_pend_vld <= 1'b0;
      end else if (w_accept) begin
        r_pend_vld  <= 1'b1;
        r_pend_addr <= addr;
        r_pend_size <= xfer_size;
        r_pend_nrd  <= n_read;
      end

      // Configuration is frozen here so mid-access register writes cannot disturb the bus cycle.
      if (w_start) begin
        r_addr  <= w_src_addr;
        r_size  <= w_src_sz;
        r_nrd   <= w_src_nrd;
        r_mw    <= w_src_mw;
        r_ws    <= w_src_nrd ? cfg_ws_wr : cfg_ws_rd;
        r_turn  <= cfg_turn;
        r_beat  <= 2'd0;
        r_last  <= w_src_last;
        r_rdata <= '0;
      end

      case (r_state)
        S_SETUP: begin
          r_cnt <= r_ws;
          if (r_beat == 2'd0) r_wdata <= write_data;
        end
        S_STROBE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!r_nrd) begin
            case (r_mw)
              2'd0:    r_rdata[{w_baddr[1:0], 3'b000} +: 8] <= ext_data_in[7:0];
              2'd1:    r_rdata[{w_baddr[1], 4'b0000} +: 16] <= ext_data_in[15:0];
              default: r_rdata <= ext_data_in;
            endcase
          end
        end
        S_HOLD: begin
          if (!w_final) r_beat <= r_beat + 2'd1;
          else if (r_turn != 2'd0) r_tcnt <= r_turn - 2'd1;
        end
        S_TURN: if (r_tcnt != 2'd0) r_tcnt <= r_tcnt - 2'd1;
        default: ;
      endcase
    end
  end

  assign ext_n_cs     = !w_active;
  assign ext_addr     = w_active ? w_baddr : 32'd0;
  assign ext_n_oe     = !((r_state == S_STROBE) && !r_nrd);
  assign ext_n_we     = !((r_state == S_STROBE) && r_nrd);
  assign ext_n_be     = w_be;
  assign ext_data_oe  = w_active && r_nrd;
  assign ext_data_out = ext_data_oe ? w_wlane : 32'd0;
  assign read_data    = r_rdata;
  assign smc_done     = (r_state == S_HOLD);
  assign mac_done     = (r_state == S_HOLD) && w_final;
  assign smc_idle     = (r_state == S_IDLE) && !r_pend_vld;

endmodule

// File: doc/smc_access_seq.md
SMC_ACCESS_SEQ -- requirements
Module: smc_access_seq

Interface
REQ-001 Parameter WS_W, default 4, width of the wait-state configuration fields.
REQ-002 hclk  input  1  system clock; all state changes on rising edge.
REQ-003 sys_reset  input  1  reset, synchronous and active-high, sampled on hclk.
REQ-004 new_access  input  1  valid AHB access to the SMC in its address phase.
REQ-005 addr  input  32  access address, valid with new_access.
REQ-006 xfer_size  input  2  access size, valid with new_access: 0=byte, 1=half, 2=word.
REQ-007 n_read  input  1  0=read, 1=write, valid with new_access.
REQ-008 write_data  input  32  AHB write data, held by the master from the cycle after acceptance until mac_done.
REQ-009 cfg_mem_width  input  2  external memory width: 0=8-bit, 1=16-bit, 2 or 3=32-bit.
REQ-010 cfg_ws_rd, cfg_ws_wr  input  WS_W each  extra strobe cycles for reads and writes.
REQ-011 cfg_turn  input  2  idle turnaround cycles after each access.
REQ-012 ext_data_in  input  32  external read data.
REQ-013 ext_addr  output  32  external beat address; ext_n_cs, ext_n_oe, ext_n_we  output  1 each  active-low strobes.
REQ-014 ext_n_be  output  4  active-low byte enables; ext_data_out  output  32; ext_data_oe  output  1  data-bus drive enable.
REQ-015 read_data  output  32  assembled read data; smc_done, mac_done, smc_idle  output  1 each.

Function
REQ-016 Parameters SHALL be sampled only at access start; later configuration changes SHALL NOT affect an access in progress.
REQ-017 FSM states: IDLE, SETUP, STROBE, HOLD, TURN.
REQ-018 Acceptance:
- new_access is accepted in IDLE, in the final-beat HOLD, or in TURN.
- addr, xfer_size and n_read are latched into a one-entry pending register.
- new_access in any other state is ignored.
REQ-019 IDLE with pending -> SETUP next cycle; pending clears on entry to SETUP.
REQ-020 Beat count = max(1, 2^xfer_size / 2^mem_width_bytes_log2); beat k address = addr + k*memory-width-bytes.
REQ-021 SETUP: 1 cycle, ext_n_cs=0, ext_addr=beat address, strobes high; write_data is latched in the first SETUP cycle of each access.
REQ-022 STROBE: 1+cfg_ws_rd (read) or 1+cfg_ws_wr (write) cycles, ext_n_cs=0, ext_n_oe=0 (read) or ext_n_we=0 (write).
REQ-023 Read data SHALL be captured from ext_data_in on the last STROBE cycle into read_data.
- Lane: beat address[1:0] for 8-bit memory, [1] for 16-bit, full word for 32-bit.
- Other lanes are unchanged; read_data clears to 0 at access start.
REQ-024 Writes:
- ext_data_out carries the write_data lane selected by the beat address on the low memory-width bits.
- ext_data_oe=1 from SETUP through HOLD.
REQ-025 ext_n_be:
- 32-bit memory: low on the lanes covered by size and addr[1:0].
- 16-bit memory: low on bits [1:0] covered by the beat.
- 8-bit memory: 4'b1110.
- All ones when ext_n_cs=1.
REQ-026 HOLD: 1 cycle, ext_n_cs=0, strobes high, smc_done=1.
- mac_done=1 only on the final beat.
- Non-final beat -> SETUP.
- Final beat -> TURN if cfg_turn>0, else IDLE (or SETUP if pending).
REQ-027 TURN: cfg_turn cycles with all strobes high, then IDLE, or SETUP if pending.
REQ-028 Outputs:
- smc_done and mac_done are single-cycle pulses.
- read_data is valid in the cycle smc_done&mac_done=1.
- smc_idle=1 only in IDLE with no pending.
REQ-029 ext_n_oe and ext_n_we SHALL never be low simultaneously; ext_data_oe=0 for reads.
REQ-030 new_access in the final-beat HOLD SHALL start its SETUP directly after HOLD/TURN with no extra IDLE cycle.

Reset
REQ-031 sys_reset=1 at a clock edge SHALL force, on that edge:
- state IDLE, pending cleared;
- ext_n_cs=ext_n_oe=ext_n_we=1, ext_n_be=4'hF, ext_data_oe=0;
- ext_addr=0, ext_data_out=0, read_data=0;
- smc_done=mac_done=0, smc_idle=1.
REQ-032 Reset mid-access SHALL abort the access without a smc_done or mac_done pulse; the first access after reset SHALL behave as from power-up.

Verification
REQ-033 Word read, 32-bit mem, ws_rd=0, turn=0, addr=0x100, ext_data_in=0xA5A5_1234 -> SETUP, STROBE, HOLD (3 cycles); read_data=0xA5A51234; smc_done=mac_done=1 in the HOLD cycle.
REQ-034 Word write 0x11223344, 8-bit mem, ws_wr=2, addr=0x200 -> 4 beats at 0x200..0x203 with ext_data_out[7:0]=44,33,22,11; 5 cycles per beat; mac_done on the 4th HOLD only.
REQ-035 Halfword read at addr 0x2, 16-bit mem -> 1 beat, ext_n_be=4'b1100, data placed in read_data[31:16].
REQ-036 turn=2, back-to-back new_access in the final HOLD -> exactly 2 TURN cycles, then SETUP of the second access; smc_idle stays 0 throughout.
REQ-037 sys_reset asserted during STROBE of a write -> next cycle all strobes=1, ext_data_oe=0, no mac_done pulse, smc_idle=1.
